// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
// Used by dmem_ctrl for store lane selection and load extension.
package dmem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b011;
  localparam logic [2:0] OP_HU = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_B, OP_BU: return 4'b0001 << lane;
      OP_H, OP_HU: return lane[1] ? 4'b1100 : 4'b0011;
      OP_W:        return 4'b1111;
      default:     return 4'b0000;
    endcase
  endfunction

  // Replicating the store data lets byte_en alone pick the target lanes.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      OP_B, OP_BU: return {4{wdata[7:0]}};
      OP_H, OP_HU: return {2{wdata[15:0]}};
      default:     return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] word,
                                           input logic [1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_B:    return 32'(b);
      OP_BU:   return {24'h0, b};
      OP_H:    return 32'(h);
      OP_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous word RAM with per-byte write enables and
// registered read data.
module dmem_bank #(
  parameter int    DEPTH_WORDS = 512,
  parameter string INIT_FILE   = "",
  parameter int    IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store at a time over valid/ready channels,
// classifies and commits on the accept edge, responds after LATENCY cycles.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 512,
  parameter int    ADDR_W      = 12,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_CAP = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [1:0] lane_q, lane_d;
  logic       err_q, err_d;
  logic       ld_q, ld_d;

  logic        accept;
  logic        illegal, misaligned, out_of_range, req_err;
  logic        bank_en;
  logic [3:0]  bank_we;
  logic [31:0] bank_rdata;

  assign accept = req_valid & req_ready;

  always_comb begin
    illegal = 1'b0;
    case (req_op)
      OP_B, OP_H, OP_W: illegal = 1'b0;
      OP_BU, OP_HU:     illegal = req_we;
      default:          illegal = 1'b1;
    endcase
    misaligned   = ((req_op == OP_H || req_op == OP_HU) && req_addr[0]) ||
                   (req_op == OP_W && req_addr[1:0] != 2'b00);
    out_of_range = 32'(req_addr) >= BYTE_CAP;
    req_err      = illegal | misaligned | out_of_range;
  end

  // Faulting requests never touch the RAM, so they leave no state behind.
  assign bank_en = accept & ~req_err;
  assign bank_we = (bank_en & req_we) ? byte_en(req_op, req_addr[1:0]) : 4'b0000;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .we   (bank_we),
    .addr (req_addr[IDX_W+1:2]),
    .wdata(store_data(req_op, req_wdata)),
    .rdata(bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lane_d  = lane_q;
    err_d   = err_q;
    ld_d    = ld_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = req_op;
          lane_d = req_addr[1:0];
          err_d  = req_err;
          ld_d   = ~req_we;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    lane_q <= lane_d;
    err_q  <= err_d;
    ld_q   <= ld_d;
  end

  // The RAM read register is only reloaded on the next accept, so it is stable through RESP.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && ld_q && !err_q) ? load_ext(op_q, bank_rdata, lane_q) : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized
// accesses scored against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int DEPTH = 512;
  localparam int LAT   = 3;

  localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2, BU = 3'd3, HU = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [11:0] req_addr = 12'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mdl [0:4*DEPTH-1];

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (12),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  // Byte-level memory semantics: n bytes little-endian at a, extended on loads.
  task automatic model(input logic we, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    bit sgn;
    logic [31:0] v;
    n = 0; sgn = 0; v = '0; rd = '0;
    case (op)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd3: n = 1;
      3'd4: n = 2;
      default: n = 0;
    endcase
    if (n == 0) er = 1;
    else if (we && op > 3'd2) er = 1;
    else if (int'(a) % n != 0) er = 1;
    else if (int'(a) >= 4 * DEPTH) er = 1;
    else er = 0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
        if (sgn && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] op, input logic [11:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1; req_we = we; req_op = op; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 0;
      lat++;
    end while (!rsp_valid && lat < 50);
    rd = rsp_rdata;
    er = rsp_err;
    if (!rsp_valid) begin
      checks++; fails++;
      $display("FAIL rsp_timeout addr=%h: rsp_valid never rose within %0d cycles", a, lat);
      lat = -1;
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  task automatic access(input logic we, input logic [2:0] op, input logic [11:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    logic [31:0] xr;
    logic xe;
    model(we, op, a, wd, xr, xe);
    do_req(we, op, a, wd, rd, er, lat);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    rst = 0;
  endtask

  task automatic init_mem();
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 64; i++) access(1, W, 12'(4*i), $urandom, rd, er, lat);
    access(1, W, 12'h7FC, $urandom, rd, er, lat);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    access(1, W, 12'h010, 32'hDEADBEEF, rd, er, lat);
    checks++; if (er !== 0 || rd !== 0) begin fails++; $display("FAIL sw_rsp got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    checks++; if (lat != LAT) begin fails++; $display("FAIL sw_latency got=%0d want=%0d", lat, LAT); end
    access(0, W, 12'h010, 32'h0, rd, er, lat);
    checks++; if (er !== 0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
    checks++; if (lat != LAT) begin fails++; $display("FAIL lw_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    access(1, B, 12'h013, 32'h00000080, rd, er, lat);
    access(0, B, 12'h013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sext got=%h want=ffffff80", rd); end
    access(0, BU, 12'h013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_zext got=%h want=00000080", rd); end
    access(0, W, 12'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL sb_merge got=%h want=80adbeef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    access(1, W, 12'h020, 32'h12345678, rd, er, lat);
    access(1, H, 12'h022, 32'h00008001, rd, er, lat);
    access(0, H, 12'h022, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh_sext got=%h want=ffff8001", rd); end
    access(0, HU, 12'h022, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu_zext got=%h want=00008001", rd); end
    access(0, H, 12'h020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00005678) begin fails++; $display("FAIL lh_low_kept got=%h want=00005678", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    access(1, W, 12'h011, 32'h55555555, rd, er, lat);
    checks++; if (er !== 1 || rd !== 0) begin fails++; $display("FAIL sw_misaligned got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    access(0, W, 12'h010, 32'h0, rd, er, lat);
    checks++; if (er !== 0 || rd !== 32'h80ADBEEF) begin fails++; $display("FAIL sw_misaligned_nowrite got=%h want=80adbeef", rd); end
    access(0, H, 12'h023, 32'h0, rd, er, lat);
    checks++; if (er !== 1 || rd !== 0) begin fails++; $display("FAIL lh_misaligned got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    access(0, 3'b101, 12'h010, 32'h0, rd, er, lat);
    checks++; if (er !== 1 || rd !== 0) begin fails++; $display("FAIL illegal_op got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    access(1, BU, 12'h010, 32'h000000AA, rd, er, lat);
    checks++; if (er !== 1) begin fails++; $display("FAIL store_bu_illegal got err=%b want=1", er); end
    access(0, W, 12'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL illegal_nowrite got=%h want=80adbeef", rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat;
    access(0, W, 12'h800, 32'h0, rd, er, lat);
    checks++; if (er !== 1 || rd !== 0) begin fails++; $display("FAIL lw_out_of_range got err=%b rdata=%h want err=1 rdata=0", er, rd); end
    access(1, W, 12'h7FC, 32'hA5A5C3C3, rd, er, lat);
    access(0, W, 12'h7FC, 32'h0, rd, er, lat);
    checks++; if (er !== 0 || rd !== 32'hA5A5C3C3) begin fails++; $display("FAIL lw_last_word got err=%b rdata=%h want err=0 rdata=a5a5c3c3", er, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_op = W; req_addr = 12'h010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_we = 1; req_op = W; req_addr = 12'h010; req_wdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1 || rsp_rdata !== 32'h80ADBEEF || req_ready !== 0) begin
        fails++;
        $display("FAIL stall[%0d] got valid=%b rdata=%h ready=%b want valid=1 rdata=80adbeef ready=0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    access(0, W, 12'h010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL stall_store_ignored got=%h want=80adbeef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] xr; logic xe;
    model(1, W, 12'h030, 32'hCAFEF00D, xr, xe);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_op = W; req_addr = 12'h030; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    checks++; if (rsp_valid !== 0 || req_ready !== 0) begin fails++; $display("FAIL in_wait got valid=%b ready=%b want 0 0", rsp_valid, req_ready); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (rsp_valid !== 0 || req_ready !== 1) begin fails++; $display("FAIL mid_reset got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready); end
    access(0, W, 12'h030, 32'h0, rd, er, lat);
    checks++; if (er !== 0 || rd !== 32'hCAFEF00D) begin fails++; $display("FAIL mid_reset_store got=%h want=cafef00d", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, xr, wd; logic er, xe; int lat;
    logic we; logic [2:0] op; logic [11:0] a;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 12'h800 + 12'($urandom_range(0, 2047));
      else a = 12'($urandom_range(0, 255));
      wd = $urandom;
      model(we, op, a, wd, xr, xe);
      do_req(we, op, a, wd, rd, er, lat);
      checks++;
      if (rd !== xr || er !== xe || lat != LAT) begin
        fails++;
        $display("FAIL rand[%0d] we=%b op=%0d addr=%h got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                 i, we, op, a, rd, er, lat, xr, xe, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
